// File: rtl/obi_sram_device_pkg.sv
// Shared OBI bus widths and bus-level types for the SRAM device slice.
package obi_sram_device_pkg;

  localparam int OBI_ADDR_W = 64;
  localparam int OBI_DATA_W = 64;
  localparam int OBI_BE_W   = OBI_DATA_W / 8;

  // Byte offset bits below the 64-bit word index; the device ignores them.
  localparam int OBI_WORD_OFS_W = $clog2(OBI_BE_W);

  typedef logic [OBI_ADDR_W-1:0] obi_addr_t;
  typedef logic [OBI_DATA_W-1:0] obi_data_t;
  typedef logic [OBI_BE_W-1:0]   obi_be_t;

endpackage

// File: rtl/obi_sram_device_if.sv
// OBI data-memory bus between the memory stage (host) and a device.
// Signal names keep the device-side port names so the bus reads like the port list.
interface obi_sram_device_if;
  import obi_sram_device_pkg::*;

  logic      req_i;
  logic      gnt_o;
  obi_addr_t addr_i;
  logic      we_i;
  obi_be_t   be_i;
  obi_data_t wdata_i;
  logic      rvalid_o;
  obi_data_t rdata_o;
  logic      err_o;

  // Host side: drives the address phase, observes grant and response.
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  // Device side: observes the address phase, drives grant and response.
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/obi_resp_pipe.sv
// Fixed-latency response pipeline: LATENCY-deep shift register of {valid, err, rdata}.
// The last stage is the registered response seen by the host.
module obi_resp_pipe #(
  parameter int LATENCY = 1,
  parameter int DATA_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_vld,
  input  logic              push_err,
  input  logic [DATA_W-1:0] push_data,
  output logic              resp_vld,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_data,
  output logic              retire
);

  logic              vld_p  [LATENCY];
  logic              err_p  [LATENCY];
  logic [DATA_W-1:0] data_p [LATENCY];

  // Shift responses one stage per cycle; reset flushes valids and zeroes data so
  // the output stays all-zero whenever no response is presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        vld_p[s]  <= 1'b0;
        err_p[s]  <= 1'b0;
        data_p[s] <= '0;
      end
    end else begin
      // stage 0: captured at the accept edge
      vld_p[0]  <= push_vld;
      err_p[0]  <= push_err;
      data_p[0] <= push_data;
      // stages 1..LATENCY-1: plain delay line
      for (int s = 1; s < LATENCY; s++) begin
        vld_p[s]  <= vld_p[s-1];
        err_p[s]  <= err_p[s-1];
        data_p[s] <= data_p[s-1];
      end
    end
  end

  assign resp_vld  = vld_p[LATENCY-1];
  assign resp_err  = err_p[LATENCY-1];
  assign resp_data = data_p[LATENCY-1];

  // retire marks the response that moves into the output stage at the coming edge.
  if (LATENCY == 1) begin : g_retire_direct
    assign retire = push_vld;
  end else begin : g_retire_stage
    assign retire = vld_p[LATENCY-2];
  end

endmodule

// File: rtl/obi_sram_device.sv
// OBI responder holding a 64-bit-wide RAM. Accepts req/gnt address phases and
// answers every accepted transaction in order, LATENCY cycles later.
module obi_sram_device
  import obi_sram_device_pkg::*;
#(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  obi_sram_device_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  // Any address bit above the word index set means the word is outside the array.
  function automatic logic addr_in_range(input obi_addr_t addr);
    return (addr[OBI_ADDR_W-1:OBI_WORD_OFS_W+IDX_W] == '0);
  endfunction

  obi_data_t        mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0] outstanding_q;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             gnt;
  logic             accept;
  logic             wr_en;
  obi_data_t        rd_word;
  logic             push_err;
  obi_data_t        push_data;
  logic             retire;
  logic             addr_lsb_unused;

  assign word_idx        = bus.addr_i[OBI_WORD_OFS_W +: IDX_W];
  assign in_range        = addr_in_range(bus.addr_i);
  assign addr_lsb_unused = ^bus.addr_i[OBI_WORD_OFS_W-1:0];

  // Grant depends only on reset and the in-flight count, never on req_i.
  assign gnt        = ~rst_i & (outstanding_q < MAX_CNT);
  assign bus.gnt_o  = gnt;
  assign accept     = bus.req_i & gnt;
  assign wr_en      = accept & bus.we_i & in_range;

  // The array is sampled before this edge's write lands; a read in the cycle
  // after a write to the same word therefore sees the new data.
  assign rd_word   = mem_q[word_idx];
  assign push_err  = accept & ~in_range;
  assign push_data = (accept & ~bus.we_i & in_range) ? rd_word : '0;

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int n = 0; n < OBI_BE_W; n++) begin
        if (bus.be_i[n]) begin
          mem_q[word_idx][8*n +: 8] <= bus.wdata_i[8*n +: 8];
        end
      end
    end
  end

  // In-flight count: +1 per accept, -1 as a response enters the output register.
  // Retiring one edge before rvalid_o is seen lets a new accept overlap the
  // cycle in which the oldest response is presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else if (accept && !retire) begin
      outstanding_q <= outstanding_q + CNT_W'(1);
    end else if (!accept && retire) begin
      outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

  obi_resp_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (OBI_DATA_W)
  ) u_resp_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_vld  (accept),
    .push_err  (push_err),
    .push_data (push_data),
    .resp_vld  (bus.rvalid_o),
    .resp_err  (bus.err_o),
    .resp_data (bus.rdata_o),
    .retire    (retire)
  );

endmodule

// File: tb/tb_obi_sram_device.sv
// Scoreboard bench for obi_sram_device: two instances (LATENCY=3 and LATENCY=4).
module tb_obi_sram_device;
  import obi_sram_device_pkg::*;

  localparam int LAT_A = 3;
  localparam int LAT_B = 4;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;
  logic exp_now_a;
  logic exp_now_b;

  logic        bp_pat  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [63:0] bp_addr [6];
  logic [63:0] bp_exp  [6];

  obi_sram_device_if bus_a ();
  obi_sram_device_if bus_b ();

  obi_sram_device #(.DEPTH_WORDS(1024), .LATENCY(LAT_A), .MAX_OUTSTANDING(2)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a)
  );

  obi_sram_device #(.DEPTH_WORDS(1024), .LATENCY(LAT_B), .MAX_OUTSTANDING(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic we, input logic [63:0] addr,
                       input logic [7:0] be, input logic [63:0] wd);
    if (sel == 0) begin
      bus_a.req_i = req; bus_a.we_i = we; bus_a.addr_i = addr; bus_a.be_i = be; bus_a.wdata_i = wd;
    end else begin
      bus_b.req_i = req; bus_b.we_i = we; bus_b.addr_i = addr; bus_b.be_i = be; bus_b.wdata_i = wd;
    end
  endtask

  task automatic push(input int sel, input logic err, input logic [63:0] rd);
    exp_t e;
    e.err   = err;
    e.rdata = rd;
    e.cyc   = cyc + ((sel == 0) ? LAT_A : LAT_B);
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // Present one transaction, wait (bounded) for grant, record the expected response.
  task automatic issue(input int sel, input logic we, input logic [63:0] addr, input logic [7:0] be,
                       input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd,
                       input logic expect_resp);
    int   w;
    logic g;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, be, wd);
    #1;
    w = 0;
    g = (sel == 0) ? bus_a.gnt_o : bus_b.gnt_o;
    while (!g && w < 20) begin
      @(negedge clk);
      #1;
      w++;
      g = (sel == 0) ? bus_a.gnt_o : bus_b.gnt_o;
    end
    check((sel == 0) ? "a_grant" : "b_grant", g, 1'b1);
    if (g && expect_resp) push(sel, exp_err, exp_rd);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
  endtask

  // Monitor A: a response is due when the head entry's cycle matches now.
  always @(negedge clk) begin
    exp_now_a = (q_a.size() > 0) && (q_a[0].cyc == cyc);
    check("a_rvalid", bus_a.rvalid_o, exp_now_a);
    if (bus_a.rvalid_o || exp_now_a) begin
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        if (bus_a.rvalid_o) begin
          check("a_rdata", bus_a.rdata_o, e_a.rdata);
          check("a_err", bus_a.err_o, e_a.err);
        end
      end
    end else begin
      check("a_idle_rdata", bus_a.rdata_o, 64'h0);
      check("a_idle_err", bus_a.err_o, 1'b0);
    end
  end

  // Monitor B: same scheme for the LATENCY=4 instance.
  always @(negedge clk) begin
    exp_now_b = (q_b.size() > 0) && (q_b[0].cyc == cyc);
    check("b_rvalid", bus_b.rvalid_o, exp_now_b);
    if (bus_b.rvalid_o || exp_now_b) begin
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        if (bus_b.rvalid_o) begin
          check("b_rdata", bus_b.rdata_o, e_b.rdata);
          check("b_err", bus_b.err_o, e_b.err);
        end
      end
    end else begin
      check("b_idle_rdata", bus_b.rdata_o, 64'h0);
      check("b_idle_err", bus_b.err_o, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k0;
    int          k;
    k0 = 64'h0F0E_0D0C_0B0A_0908;
    bp_addr = '{64'h0, 64'h10, 64'h18, 64'h0, 64'h10, 64'h18};
    bp_exp  = '{64'h0F0E_0D0C_0B0A_0908, 64'h1122_3344_BBBB_BBBB, 64'hAB00_0000_0000_00CD,
                64'h0F0E_0D0C_0B0A_0908, 64'h1122_3344_BBBB_BBBB, 64'hAB00_0000_0000_00CD};

    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    drive(1, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    check("a_gnt_in_reset", bus_a.gnt_o, 1'b0);
    check("b_gnt_in_reset", bus_b.gnt_o, 1'b0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("a_gnt_after_reset", bus_a.gnt_o, 1'b1);
    check("b_gnt_after_reset", bus_b.gnt_o, 1'b1);

    // Full writes, write-then-read, partial write, ignored byte offset, be=0 no-op
    issue(0, 1'b1, 64'h0,  8'hFF, k0,                    1'b0, 64'h0, 1'b1);
    issue(0, 1'b1, 64'h10, 8'hFF, 64'h1122334455667788,  1'b0, 64'h0, 1'b1);
    issue(0, 1'b0, 64'h10, 8'h00, 64'h0,                 1'b0, 64'h1122334455667788, 1'b1);
    issue(0, 1'b1, 64'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 64'h0, 1'b1);
    issue(0, 1'b0, 64'h10, 8'hFF, 64'h0,                 1'b0, 64'h11223344_BBBBBBBB, 1'b1);
    issue(0, 1'b0, 64'h17, 8'h00, 64'h0,                 1'b0, 64'h11223344_BBBBBBBB, 1'b1);
    issue(0, 1'b1, 64'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b1);
    issue(0, 1'b0, 64'h10, 8'h00, 64'h0,                 1'b0, 64'h11223344_BBBBBBBB, 1'b1);
    issue(0, 1'b1, 64'h18, 8'hFF, 64'h0,                 1'b0, 64'h0, 1'b1);
    issue(0, 1'b1, 64'h18, 8'h81, 64'hAB11_2233_4455_66CD, 1'b0, 64'h0, 1'b1);
    issue(0, 1'b0, 64'h18, 8'h00, 64'h0,                 1'b0, 64'hAB00_0000_0000_00CD, 1'b1);

    // Out of range: errors with zero data, aliasing write must not reach word 0
    issue(0, 1'b0, 64'h2000, 8'h00, 64'h0,               1'b1, 64'h0, 1'b1);
    issue(0, 1'b1, 64'h2000, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h0, 1'b1);
    issue(0, 1'b1, 64'h8000_0000_0000_0010, 8'hFF, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1);
    issue(0, 1'b0, 64'h0,    8'h00, 64'h0,               1'b0, k0, 1'b1);
    issue(0, 1'b0, 64'h10,   8'h00, 64'h0,               1'b0, 64'h11223344_BBBBBBBB, 1'b1);
    repeat (8) @(negedge clk);

    // Request held six cycles with LATENCY=3 and two outstanding
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b0, bp_addr[k], 8'h00, 64'h0);
      #1;
      check("a_bp_gnt", bus_a.gnt_o, bp_pat[i]);
      if (bus_a.gnt_o && k < 5) begin
        push(0, 1'b0, bp_exp[k]);
        k++;
      end
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    repeat (8) @(negedge clk);

    // Reset held three cycles with a write request pending: no grant, no write
    @(negedge clk);
    rst_a = 1'b1;
    drive(0, 1'b1, 1'b1, 64'h0, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("a_gnt_req_in_reset", bus_a.gnt_o, 1'b0);
      @(negedge clk);
    end
    rst_a = 1'b0;
    drive(0, 1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    #1;
    check("a_gnt_post_reset", bus_a.gnt_o, 1'b1);
    issue(0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, k0, 1'b1);

    // LATENCY=4 instance: two reads in flight are dropped by a reset
    issue(1, 1'b1, 64'h8, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1'b1);
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 64'h8, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0);
    issue(1, 1'b0, 64'h8, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("b_gnt_midflight_reset", bus_b.gnt_o, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("b_gnt_first_after_reset", bus_b.gnt_o, 1'b1);
    issue(1, 1'b0, 64'h8, 8'h00, 64'h0, 1'b0, 64'h0123456789ABCDEF, 1'b1);
    repeat (12) @(negedge clk);

    check("a_queue_drained", q_a.size(), 64'h0);
    check("b_queue_drained", q_b.size(), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
